// File: rtl/ocx_tlx_crd_pkg.sv
// Shared types and constants for the TLX receive credit-return scheduler.
// Contents: FSM state encoding and credit-return packet field widths/maxima.
package ocx_tlx_crd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GATHER  = 2'd1,
      PRESENT = 2'd2
   } crd_state_e;

   localparam int VC_FLD_W    = 4;
   localparam int DCP_FLD_W   = 6;
   localparam int VC_FLD_MAX  = (1 << VC_FLD_W) - 1;
   localparam int DCP_FLD_MAX = (1 << DCP_FLD_W) - 1;

endpackage

// File: rtl/ocx_tlx_crd_acc.sv
// Saturating per-pool credit accumulator.
// Ports:
//   tlx_clk, reset_n   clock, synchronous active-low reset
//   i_incr             credits released this cycle (0..2)
//   i_taken            credits removed by a capture this cycle (0 otherwise)
//   o_acc              registered accumulator value
//   o_cap              registered value clamped to the packet field maximum
//   o_nz_next          accumulator will be nonzero after this edge
//   o_ovf              this cycle's update saturated
// i_taken never exceeds o_acc (it is either 0 or o_cap), so the update cannot
// underflow. ACC_W must be at least FLD_W.
module ocx_tlx_crd_acc #(
   parameter int ACC_W = 8,
   parameter int FLD_W = 4
) (
   input  logic             tlx_clk,
   input  logic             reset_n,
   input  logic [1:0]       i_incr,
   input  logic [FLD_W-1:0] i_taken,
   output logic [ACC_W-1:0] o_acc,
   output logic [FLD_W-1:0] o_cap,
   output logic             o_nz_next,
   output logic             o_ovf
);

   localparam logic [ACC_W-1:0] FLD_MAX = ACC_W'((1 << FLD_W) - 1);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W:0]   w_sum;
   logic [ACC_W-1:0] w_acc_next;

   assign w_sum      = {1'b0, r_acc} - (ACC_W+1)'(i_taken) + (ACC_W+1)'(i_incr);
   assign o_ovf      = w_sum[ACC_W];
   assign w_acc_next = o_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
   assign o_nz_next  = |w_acc_next;
   assign o_acc      = r_acc;
   assign o_cap      = (r_acc > FLD_MAX) ? FLD_MAX[FLD_W-1:0] : r_acc[FLD_W-1:0];

   always_ff @(posedge tlx_clk) begin
      if (!reset_n) r_acc <= '0;
      else          r_acc <= w_acc_next;
   end

endmodule

// File: rtl/ocx_tlx_rcv_crd_ret_sched.sv
// Receive-side credit-return scheduler: batches per-cycle credit releases from
// the VC0/VC1/DCP0/DCP1 pools and presents one credit-return packet at a time
// to the transmit framer over a valid/ack handshake.
// Ports:
//   tlx_clk, reset_n                  clock, synchronous active-low reset
//   rcv_xmt_credit_*_v                one credit released per pool this cycle
//   rcv_xmt_tl_crd_cfg_dcp1_valid     extra DCP1 credit (cfg data)
//   crd_ret_enable                    presentation allowed
//   xmt_crd_ret_ack                   framer accepted the packet
//   crd_ret_valid, crd_ret_vc0/vc1/dcp0/dcp1   presented packet
//   crd_ovfl_err                      sticky accumulator saturation
// Optional build macro OCX_TLX_CRD_RET_TOTALS_EN adds 32-bit wrapping counters
// crd_ret_total_* of credits delivered on ack.
//
// state   | meaning
// IDLE    | nothing accumulated
// GATHER  | credits pending, waiting for threshold/timeout with enable
// PRESENT | packet valid, fields held until ack
module ocx_tlx_rcv_crd_ret_sched
   import ocx_tlx_crd_pkg::*;
#(
   parameter int ACC_W      = 8,
   parameter int TIMEOUT    = 16,
   parameter int VC_THRESH  = 8,
   parameter int DCP_THRESH = 16
) (
   input  logic                 tlx_clk,
   input  logic                 reset_n,
   input  logic                 rcv_xmt_credit_vc0_v,
   input  logic                 rcv_xmt_credit_vc1_v,
   input  logic                 rcv_xmt_credit_dcp0_v,
   input  logic                 rcv_xmt_credit_dcp1_v,
   input  logic                 rcv_xmt_tl_crd_cfg_dcp1_valid,
   input  logic                 crd_ret_enable,
   input  logic                 xmt_crd_ret_ack,
   output logic                 crd_ret_valid,
   output logic [VC_FLD_W-1:0]  crd_ret_vc0,
   output logic [VC_FLD_W-1:0]  crd_ret_vc1,
   output logic [DCP_FLD_W-1:0] crd_ret_dcp0,
   output logic [DCP_FLD_W-1:0] crd_ret_dcp1,
`ifdef OCX_TLX_CRD_RET_TOTALS_EN
   output logic [31:0]          crd_ret_total_vc0,
   output logic [31:0]          crd_ret_total_vc1,
   output logic [31:0]          crd_ret_total_dcp0,
   output logic [31:0]          crd_ret_total_dcp1,
`endif
   output logic                 crd_ovfl_err
);

   // Timer saturates at its hit value so a late enable still sees the compare.
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_HIT = TMR_W'(TIMEOUT - 1);

   crd_state_e           r_state;
   logic [TMR_W-1:0]     r_tmr;
   logic                 r_valid;
   logic [VC_FLD_W-1:0]  r_vc0, r_vc1;
   logic [DCP_FLD_W-1:0] r_dcp0, r_dcp1;
   logic                 r_err;

   logic [ACC_W-1:0]     w_acc_vc0, w_acc_vc1, w_acc_dcp0, w_acc_dcp1;
   logic [VC_FLD_W-1:0]  w_cap_vc0, w_cap_vc1, w_take_vc0, w_take_vc1;
   logic [DCP_FLD_W-1:0] w_cap_dcp0, w_cap_dcp1, w_take_dcp0, w_take_dcp1;
   logic [3:0]           w_nz_next, w_ovf;
   logic [1:0]           w_incr_dcp1;
   logic                 w_any_nz, w_thresh, w_capture;

   assign w_incr_dcp1 = {1'b0, rcv_xmt_credit_dcp1_v} + {1'b0, rcv_xmt_tl_crd_cfg_dcp1_valid};

   assign w_any_nz = |{w_acc_vc0, w_acc_vc1, w_acc_dcp0, w_acc_dcp1};
   assign w_thresh = (w_acc_vc0  >= ACC_W'(VC_THRESH))  || (w_acc_vc1  >= ACC_W'(VC_THRESH)) ||
                     (w_acc_dcp0 >= ACC_W'(DCP_THRESH)) || (w_acc_dcp1 >= ACC_W'(DCP_THRESH));
   // w_any_nz keeps an all-zero packet from ever being captured.
   assign w_capture = (r_state == GATHER) && crd_ret_enable && w_any_nz &&
                      ((r_tmr == TMR_HIT) || w_thresh);

   assign w_take_vc0  = w_capture ? w_cap_vc0  : '0;
   assign w_take_vc1  = w_capture ? w_cap_vc1  : '0;
   assign w_take_dcp0 = w_capture ? w_cap_dcp0 : '0;
   assign w_take_dcp1 = w_capture ? w_cap_dcp1 : '0;

   ocx_tlx_crd_acc #(.ACC_W(ACC_W), .FLD_W(VC_FLD_W)) u_acc_vc0 (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_incr({1'b0, rcv_xmt_credit_vc0_v}),
      .i_taken(w_take_vc0), .o_acc(w_acc_vc0), .o_cap(w_cap_vc0),
      .o_nz_next(w_nz_next[0]), .o_ovf(w_ovf[0]));

   ocx_tlx_crd_acc #(.ACC_W(ACC_W), .FLD_W(VC_FLD_W)) u_acc_vc1 (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_incr({1'b0, rcv_xmt_credit_vc1_v}),
      .i_taken(w_take_vc1), .o_acc(w_acc_vc1), .o_cap(w_cap_vc1),
      .o_nz_next(w_nz_next[1]), .o_ovf(w_ovf[1]));

   ocx_tlx_crd_acc #(.ACC_W(ACC_W), .FLD_W(DCP_FLD_W)) u_acc_dcp0 (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_incr({1'b0, rcv_xmt_credit_dcp0_v}),
      .i_taken(w_take_dcp0), .o_acc(w_acc_dcp0), .o_cap(w_cap_dcp0),
      .o_nz_next(w_nz_next[2]), .o_ovf(w_ovf[2]));

   ocx_tlx_crd_acc #(.ACC_W(ACC_W), .FLD_W(DCP_FLD_W)) u_acc_dcp1 (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_incr(w_incr_dcp1),
      .i_taken(w_take_dcp1), .o_acc(w_acc_dcp1), .o_cap(w_cap_dcp1),
      .o_nz_next(w_nz_next[3]), .o_ovf(w_ovf[3]));

   always_ff @(posedge tlx_clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_tmr   <= '0;
         r_valid <= 1'b0;
         r_vc0   <= '0;
         r_vc1   <= '0;
         r_dcp0  <= '0;
         r_dcp1  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_nz) begin
                  r_state <= GATHER;
                  r_tmr   <= '0;
               end
            end
            GATHER: begin
               if (w_capture) begin
                  r_state <= PRESENT;
                  r_valid <= 1'b1;
                  r_vc0   <= w_cap_vc0;
                  r_vc1   <= w_cap_vc1;
                  r_dcp0  <= w_cap_dcp0;
                  r_dcp1  <= w_cap_dcp1;
               end else if (r_tmr != TMR_HIT) begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            PRESENT: begin
               if (xmt_crd_ret_ack) begin
                  r_state <= (|w_nz_next) ? GATHER : IDLE;
                  r_tmr   <= '0;
                  r_valid <= 1'b0;
                  r_vc0   <= '0;
                  r_vc1   <= '0;
                  r_dcp0  <= '0;
                  r_dcp1  <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge tlx_clk) begin
      if (!reset_n)    r_err <= 1'b0;
      else if (|w_ovf) r_err <= 1'b1;
   end

   assign crd_ret_valid = r_valid;
   assign crd_ret_vc0   = r_vc0;
   assign crd_ret_vc1   = r_vc1;
   assign crd_ret_dcp0  = r_dcp0;
   assign crd_ret_dcp1  = r_dcp1;
   assign crd_ovfl_err  = r_err;

`ifdef OCX_TLX_CRD_RET_TOTALS_EN
   logic [31:0] r_total_vc0, r_total_vc1, r_total_dcp0, r_total_dcp1;

   always_ff @(posedge tlx_clk) begin
      if (!reset_n) begin
         r_total_vc0  <= '0;
         r_total_vc1  <= '0;
         r_total_dcp0 <= '0;
         r_total_dcp1 <= '0;
      end else if ((r_state == PRESENT) && xmt_crd_ret_ack) begin
         r_total_vc0  <= r_total_vc0  + 32'(r_vc0);
         r_total_vc1  <= r_total_vc1  + 32'(r_vc1);
         r_total_dcp0 <= r_total_dcp0 + 32'(r_dcp0);
         r_total_dcp1 <= r_total_dcp1 + 32'(r_dcp1);
      end
   end

   assign crd_ret_total_vc0  = r_total_vc0;
   assign crd_ret_total_vc1  = r_total_vc1;
   assign crd_ret_total_dcp0 = r_total_dcp0;
   assign crd_ret_total_dcp1 = r_total_dcp1;
`endif

endmodule

// File: tb/tb_ocx_tlx_rcv_crd_ret_sched.sv
// Directed testbench for ocx_tlx_rcv_crd_ret_sched with default parameters
// (TIMEOUT=16, VC_THRESH=8, DCP_THRESH=16, ACC_W=8).
// "Edge N" is the Nth rising edge after the first stimulus pulse is driven;
// outputs are sampled 1ns after each edge.
module tb_ocx_tlx_rcv_crd_ret_sched;

   logic       tlx_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       vc0_v = 1'b0, vc1_v = 1'b0, dcp0_v = 1'b0, dcp1_v = 1'b0, cfg_v = 1'b0;
   logic       enable = 1'b0, ack = 1'b0;
   logic       crd_ret_valid, crd_ovfl_err;
   logic [3:0] crd_ret_vc0, crd_ret_vc1;
   logic [5:0] crd_ret_dcp0, crd_ret_dcp1;
`ifdef OCX_TLX_CRD_RET_TOTALS_EN
   logic [31:0] tot_vc0, tot_vc1, tot_dcp0, tot_dcp1;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 tlx_clk = ~tlx_clk;

   ocx_tlx_rcv_crd_ret_sched dut (
      .tlx_clk                       (tlx_clk),
      .reset_n                       (reset_n),
      .rcv_xmt_credit_vc0_v          (vc0_v),
      .rcv_xmt_credit_vc1_v          (vc1_v),
      .rcv_xmt_credit_dcp0_v         (dcp0_v),
      .rcv_xmt_credit_dcp1_v         (dcp1_v),
      .rcv_xmt_tl_crd_cfg_dcp1_valid (cfg_v),
      .crd_ret_enable                (enable),
      .xmt_crd_ret_ack               (ack),
      .crd_ret_valid                 (crd_ret_valid),
      .crd_ret_vc0                   (crd_ret_vc0),
      .crd_ret_vc1                   (crd_ret_vc1),
      .crd_ret_dcp0                  (crd_ret_dcp0),
      .crd_ret_dcp1                  (crd_ret_dcp1),
`ifdef OCX_TLX_CRD_RET_TOTALS_EN
      .crd_ret_total_vc0             (tot_vc0),
      .crd_ret_total_vc1             (tot_vc1),
      .crd_ret_total_dcp0            (tot_dcp0),
      .crd_ret_total_dcp1            (tot_dcp1),
`endif
      .crd_ovfl_err                  (crd_ovfl_err)
   );

   task automatic tick();
      @(posedge tlx_clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if (crd_ret_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid: got %b expected 0", crd_ret_valid);
      end
      n_vec++;
      if ({crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_fields: got %h expected 00000",
                  {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1});
      end
      n_vec++;
      if (crd_ovfl_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_err: got %b expected 0", crd_ovfl_err);
      end
      reset_n = 1'b1;
      tick();
   endtask

   // Lone VC0 pulse: timeout path, valid exactly at edge 17, gone at 18.
   task automatic test_single_pulse();
      int seen;
      enable = 1'b1;
      ack    = 1'b1;
      vc0_v  = 1'b1;
      tick();
      vc0_v  = 1'b0;
      for (int e = 1; e <= 18; e++) begin
         tick();
         n_vec++;
         if (crd_ret_valid !== (e == 17)) begin
            n_err++;
            $display("FAIL single_valid edge %0d: got %b expected %b", e, crd_ret_valid, (e == 17));
         end
         if (e == 17) begin
            n_vec++;
            if ({crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1} !== {4'd1, 4'd0, 6'd0, 6'd0}) begin
               n_err++;
               $display("FAIL single_fields: got %h expected %h",
                        {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1},
                        {4'd1, 4'd0, 6'd0, 6'd0});
            end
         end
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (crd_ret_valid) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL single_idle: got %0d valid cycles expected 0", seen);
      end
   endtask

   // 20 back-to-back VC1 pulses, ack held off: threshold capture of 8, the
   // pulse in the capture cycle stays behind, enable drop mid-present ignored.
   task automatic test_back_to_back();
      ack    = 1'b0;
      enable = 1'b1;
      vc1_v  = 1'b1;
      tick();
      for (int e = 1; e <= 33; e++) begin
         vc1_v  = (e <= 19);
         ack    = (e >= 30);
         enable = !((e >= 15) && (e <= 25));
         tick();
         n_vec++;
         if (e <= 7 || e == 30 || e >= 32) begin
            if (crd_ret_valid !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_valid edge %0d: got %b expected 0", e, crd_ret_valid);
            end
         end else if (e <= 29) begin
            if (crd_ret_valid !== 1'b1 || crd_ret_vc1 !== 4'd8) begin
               n_err++;
               $display("FAIL b2b_first edge %0d: got valid=%b vc1=%0d expected valid=1 vc1=8",
                        e, crd_ret_valid, crd_ret_vc1);
            end
         end else begin
            if (crd_ret_valid !== 1'b1 ||
                {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1} !== {4'd0, 4'd12, 6'd0, 6'd0}) begin
               n_err++;
               $display("FAIL b2b_second: got valid=%b fields=%h expected valid=1 fields=%h",
                        crd_ret_valid, {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1},
                        {4'd0, 4'd12, 6'd0, 6'd0});
            end
         end
      end
      ack    = 1'b0;
      enable = 1'b1;
   endtask

   // Both DCP1 sources for 10 cycles: packet of 16, remainder 4 after timeout.
   task automatic test_dcp1_dual();
      ack    = 1'b0;
      dcp1_v = 1'b1;
      cfg_v  = 1'b1;
      tick();
      for (int e = 1; e <= 29; e++) begin
         dcp1_v = (e <= 9);
         cfg_v  = (e <= 9);
         ack    = (e == 12) || (e == 29);
         tick();
         n_vec++;
         if (e <= 7 || (e >= 12 && e <= 27) || e == 29) begin
            if (crd_ret_valid !== 1'b0) begin
               n_err++;
               $display("FAIL dcp1_valid edge %0d: got %b expected 0", e, crd_ret_valid);
            end
         end else if (e <= 11) begin
            if (crd_ret_valid !== 1'b1 ||
                {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1} !== {4'd0, 4'd0, 6'd0, 6'd16}) begin
               n_err++;
               $display("FAIL dcp1_first edge %0d: got valid=%b dcp1=%0d expected valid=1 dcp1=16",
                        e, crd_ret_valid, crd_ret_dcp1);
            end
         end else begin
            if (crd_ret_valid !== 1'b1 ||
                {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1} !== {4'd0, 4'd0, 6'd0, 6'd4}) begin
               n_err++;
               $display("FAIL dcp1_remainder: got valid=%b dcp1=%0d expected valid=1 dcp1=4",
                        crd_ret_valid, crd_ret_dcp1);
            end
         end
      end
      ack = 1'b0;
   endtask

   // Enable low while 300 VC0 pulses saturate the accumulator at 255, then
   // drain in packets of 15.
   task automatic test_saturation();
      int seen, pkts, sum;
      enable = 1'b0;
      ack    = 1'b1;
      vc0_v  = 1'b1;
      seen   = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (crd_ret_valid) seen++;
      end
      vc0_v = 1'b0;
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL sat_no_valid: got %0d valid cycles expected 0", seen);
      end
      n_vec++;
      if (crd_ovfl_err !== 1'b1) begin
         n_err++;
         $display("FAIL sat_err: got %b expected 1", crd_ovfl_err);
      end
      enable = 1'b1;
      pkts   = 0;
      sum    = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (crd_ret_valid) begin
            pkts++;
            sum += int'(crd_ret_vc0);
            n_vec++;
            if (crd_ret_vc0 !== 4'd15) begin
               n_err++;
               $display("FAIL sat_pkt %0d: got vc0=%0d expected 15", pkts, crd_ret_vc0);
            end
         end
      end
      n_vec++;
      if (pkts != 17 || sum != 255) begin
         n_err++;
         $display("FAIL sat_drain: got %0d packets %0d credits expected 17 packets 255 credits", pkts, sum);
      end
      n_vec++;
      if (crd_ovfl_err !== 1'b1) begin
         n_err++;
         $display("FAIL sat_err_sticky: got %b expected 1", crd_ovfl_err);
      end
`ifdef OCX_TLX_CRD_RET_TOTALS_EN
      // 1 credit from the single-pulse test plus 255 here.
      n_vec++;
      if (tot_vc0 !== 32'd256) begin
         n_err++;
         $display("FAIL total_vc0: got %0d expected 256", tot_vc0);
      end
`endif
   endtask

   // Reset while a packet is presented and credits are pending.
   task automatic test_reset_mid_packet();
      int seen;
      ack    = 1'b0;
      enable = 1'b1;
      vc0_v  = 1'b1;
      tick();
      for (int e = 1; e <= 11; e++) begin
         vc0_v = (e <= 9);
         tick();
      end
      n_vec++;
      if (crd_ret_valid !== 1'b1 || crd_ret_vc0 !== 4'd8) begin
         n_err++;
         $display("FAIL mid_setup: got valid=%b vc0=%0d expected valid=1 vc0=8", crd_ret_valid, crd_ret_vc0);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_vec++;
      if ({crd_ret_valid, crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1, crd_ovfl_err} !== 22'h0) begin
         n_err++;
         $display("FAIL mid_reset: got valid=%b fields=%h err=%b expected all 0", crd_ret_valid,
                  {crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1}, crd_ovfl_err);
      end
      ack  = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (crd_ret_valid) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL mid_discard: got %0d valid cycles expected 0", seen);
      end
      vc0_v = 1'b1;
      tick();
      vc0_v = 1'b0;
      for (int e = 1; e <= 18; e++) begin
         tick();
         if (e >= 16) begin
            n_vec++;
            if (crd_ret_valid !== (e == 17)) begin
               n_err++;
               $display("FAIL mid_restart edge %0d: got %b expected %b", e, crd_ret_valid, (e == 17));
            end
         end
      end
   endtask

`ifdef OCX_TLX_CRD_RET_TOTALS_EN
   task automatic test_total_wrap();
      dut.r_total_vc0 = 32'hFFFF_FFF0;
      ack    = 1'b1;
      enable = 1'b1;
      vc0_v  = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      vc0_v = 1'b0;
      for (int i = 0; i < 60; i++) tick();
      n_vec++;
      if (tot_vc0 !== 32'd4) begin
         n_err++;
         $display("FAIL total_wrap: got %h expected 00000004", tot_vc0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_pulse();
      test_back_to_back();
      test_dcp1_dual();
      test_saturation();
      test_reset_mid_packet();
`ifdef OCX_TLX_CRD_RET_TOTALS_EN
      test_total_wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
